conv_window_gen_3x3: RTL

Upstream feeder for the 3x3 convolution stage. It takes a raster-order stream of 8-bit unsigned pixels, one per valid beat, and stores the two previous image rows in line buffers. It emits one 3x3 window per accepted pixel once the window is complete (valid-only convolution, no padding). The nine taps connect directly to the convolution stage's nine unsigned 8-bit data inputs, together with a window-valid strobe.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_window_gen_3x3_if.sv | 32 +++
 rtl/conv_window_gen_3x3_line_buf_row.sv | 27 ++
 rtl/conv_window_gen_3x3.sv | 96 +++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window generator and the convolution stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // Window tap order; conv weights_data[8k+7:8k] pairs with tap k.
  // Row-major: top row (r-2) first, left column (c-2) first.
  localparam int TAP_TL = 0;
  localparam int TAP_TM = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MM = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BM = 7;
  localparam int TAP_BR = 8;
  localparam int N_TAPS = 9;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [N_TAPS-1:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/conv_window_gen_3x3_if.sv
// Pixel-in / window-out signal bundle for conv_window_gen_3x3.
// Latency: n/a (wiring only).
// Backpressure: none; the window consumer is always ready.
interface conv_window_gen_3x3_if
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
);

  logic                     pix_valid;
  pix_t                     pix_data;
  logic                     pix_sof;
  logic                     win_valid;
  win_t                     win;      // win[k] is tap win_k
  logic                     win_last;
  logic [$clog2(IMG_W)-1:0] col_idx;
  logic [$clog2(IMG_H)-1:0] row_idx;

  // Pixel source side.
  modport master (
    output pix_valid, pix_data, pix_sof,
    input  win_valid, win, win_last, col_idx, row_idx
  );

  // Window generator side.
  modport slave (
    input  pix_valid, pix_data, pix_sof,
    output win_valid, win, win_last, col_idx, row_idx
  );

endinterface

// File: rtl/conv_window_gen_3x3_line_buf_row.sv
// One image-row delay line: DEPTH entries of WIDTH bits, shared read/write address.
// Latency: read is combinational; a same-cycle write lands on the clock edge, so reads see old data.
// Backpressure: none; writes whenever we is high.
module line_buf_row
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  // Storage is deliberately unreset: every entry is written in a frame before it is read.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the new value after the old one has been presented on rdata.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Raster pixel stream to 3x3 sliding window (valid-only, no padding) for the conv stage.
// Latency: 1 clk from accepted pixel to taps / win_valid / win_last.
// Backpressure: none; every pix_valid beat is accepted and downstream is always ready.
module conv_window_gen_3x3
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_window_gen_3x3_if.slave  io
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          accept;
  logic          sof;
  logic [CW-1:0] col_q, eff_col, col_nxt;
  logic [RW-1:0] row_q, eff_row, row_nxt;
  logic          col_end, row_end;
  pix_t          tap_top, tap_mid;
  win_t          win_q;
  logic          win_valid_q, win_last_q;

  assign accept = io.pix_valid;
  assign sof    = io.pix_valid & io.pix_sof;

  // Position of the pixel on the bus: sof overrides the counters with (0,0).
  always_comb begin
    eff_col = sof ? '0 : col_q;
    eff_row = sof ? '0 : row_q;
    col_end = (eff_col == CW'(IMG_W - 1));
    row_end = (eff_row == RW'(IMG_H - 1));
    col_nxt = col_end ? '0 : eff_col + 1'b1;
    row_nxt = eff_row;
    if (col_end) row_nxt = row_end ? '0 : eff_row + 1'b1;
  end

  // lb1 holds the previous row, lb2 the row before it; lb2 is fed by lb1's old data.
  line_buf_row #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (eff_col),
    .wdata (io.pix_data),
    .rdata (tap_mid)
  );

  line_buf_row #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (eff_col),
    .wdata (tap_mid),
    .rdata (tap_top)
  );

  // Advance counters, shift the window left by one column and flag complete windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      // Only interior positions form a full window; row-wrap columns 0/1 never qualify.
      win_valid_q <= accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      win_last_q  <= accept && row_end && col_end;
      if (accept) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
        if (sof) begin
          win_q <= '0;
        end else begin
          win_q[TAP_TL] <= win_q[TAP_TM];
          win_q[TAP_TM] <= win_q[TAP_TR];
          win_q[TAP_TR] <= tap_top;
          win_q[TAP_ML] <= win_q[TAP_MM];
          win_q[TAP_MM] <= win_q[TAP_MR];
          win_q[TAP_MR] <= tap_mid;
          win_q[TAP_BL] <= win_q[TAP_BM];
          win_q[TAP_BM] <= win_q[TAP_BR];
          win_q[TAP_BR] <= io.pix_data;
        end
      end
    end
  end

  assign io.win_valid = win_valid_q;
  assign io.win_last  = win_last_q;
  assign io.win       = win_q;
  assign io.col_idx   = col_q;
  assign io.row_idx   = row_q;

endmodule
